fp_align_adder: RTL

FP_ALIGN_ADDER -- requirements
Module: fp_align_adder

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/align_shifter.sv | 38 +++
 rtl/fp_align_adder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared constants, types and helpers for the single-precision alignment adder.
//   EXP_W/FRAC_W/MANT_W/BIAS : IEEE-754 single field widths and exponent bias
//   OP_ADD/OP_SUB            : effective magnitude operation encoding
//   fp32_t                   : unpacked operand (sign, raw exponent, alignment
//                              exponent, 27-bit working mantissa)
//   fp_unpack()              : splits a 32-bit word into fp32_t
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 27;
    localparam int BIAS   = 127;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;      // exponent field as received
        logic [EXP_W-1:0]  exp_eff;  // exponent used for alignment (denormal -> 1)
        logic [MANT_W-1:0] mant;     // {hidden, fraction, guard/round/sticky}
    } fp32_t;

    function automatic fp32_t fp_unpack(input logic [31:0] x);
        fp32_t u;
        logic  hidden;
        hidden    = (x[30:23] != '0);
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.exp_eff = hidden ? x[30:23] : 8'd1;
        u.mant    = {hidden, x[FRAC_W-1:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/align_shifter.sv
// -----------------------------------------------------------------------------
// align_shifter
// Combinational right shift of the smaller operand's mantissa with sticky
// collection: every bit pushed off the bottom is ORed into bit 0. Shifts of
// MANT_W or more leave only the sticky bit.
//   mant_in  : 27-bit mantissa {hidden, fraction, 3'b000}
//   shift    : exponent difference
//   mant_out : aligned mantissa, bit 0 carries the sticky
// -----------------------------------------------------------------------------
module align_shifter
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  shift,
    output logic [MANT_W-1:0] mant_out
);

    logic [MANT_W-1:0] lost_bits;
    logic [MANT_W-1:0] shifted;
    logic              sticky;

    // Bit gi falls off the bottom exactly when the shift distance exceeds gi.
    generate
        for (genvar gi = 0; gi < MANT_W; gi++) begin : g_lost
            assign lost_bits[gi] = mant_in[gi] && (shift > EXP_W'(gi));
        end
    endgenerate

    always_comb begin
        shifted = '0;
        if (shift < EXP_W'(MANT_W)) begin
            shifted = mant_in >> shift;
        end
        sticky   = |lost_bits;
        mant_out = {shifted[MANT_W-1:1], shifted[0] | sticky};
    end

endmodule

// File: rtl/fp_align_adder.sv
// -----------------------------------------------------------------------------
// fp_align_adder
// Two-stage IEEE-754 single-precision align-and-add front end. Stage 1 unpacks
// and orders the operands by magnitude; stage 2 aligns the smaller mantissa
// and adds or subtracts magnitudes. Normalisation/rounding happen downstream.
// Valid/ready handshake on both sides, one result per cycle, latency 2.
//   clk, arst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready  : input handshake for a, b, op_in (0 = A+B, 1 = A-B)
//   out_valid/out_ready: output handshake
//   result_mant        : {integer bit, 23-bit fraction, guard, round, sticky}
//   carry_out          : bit 27 of an effective-add sum
//   exp_result         : exponent field of the larger-magnitude operand
//   result_sign        : sign of the result (+0 for an exact-zero subtract)
//   op                 : effective operation (OP_ADD / OP_SUB)
//   special            : an operand had exp=255; only when FPU_ALIGN_SPECIAL_EN
//                        is defined, otherwise such operands are processed
//                        arithmetically
// -----------------------------------------------------------------------------
module fp_align_adder
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              op_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] result_mant,
    output logic              carry_out,
    output logic [EXP_W-1:0]  exp_result,
    output logic              result_sign,
    output logic              op
`ifdef FPU_ALIGN_SPECIAL_EN
    ,
    output logic              special
`endif
);

    // ---------------- handshake ----------------
    logic s1_valid_reg;
    logic out_valid_reg;
    logic s1_advance;

    assign s1_advance = !out_valid_reg || out_ready;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign out_valid  = out_valid_reg;

    // ---------------- stage 1: unpack and order ----------------
    fp32_t             ua, ub;
    logic              swap;
    logic [MANT_W-1:0] big_mant_next, small_mant_next;
    logic [EXP_W-1:0]  shift_next, exp_next;
    logic              sign_next, op_next;

    always_comb begin
        ua = fp_unpack(a);
        ub = fp_unpack(b);
        // Strictly-greater test keeps A on top when magnitudes tie.
        swap            = ({ub.exp_eff, ub.mant} > {ua.exp_eff, ua.mant});
        big_mant_next   = swap ? ub.mant : ua.mant;
        small_mant_next = swap ? ua.mant : ub.mant;
        exp_next        = swap ? ub.exp  : ua.exp;
        shift_next      = swap ? (ub.exp_eff - ua.exp_eff) : (ua.exp_eff - ub.exp_eff);
        // When B ends up on top, a subtract request flips its sign.
        sign_next       = swap ? (ub.sign ^ op_in) : ua.sign;
        op_next         = op_in ^ ua.sign ^ ub.sign;
    end

    logic [MANT_W-1:0] s1_big_mant_reg, s1_small_mant_reg;
    logic [EXP_W-1:0]  s1_shift_reg, s1_exp_reg;
    logic              s1_sign_reg, s1_op_reg;
`ifdef FPU_ALIGN_SPECIAL_EN
    logic              s1_special_reg;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid_reg      <= 1'b0;
            s1_big_mant_reg   <= '0;
            s1_small_mant_reg <= '0;
            s1_shift_reg      <= '0;
            s1_exp_reg        <= '0;
            s1_sign_reg       <= 1'b0;
            s1_op_reg         <= OP_ADD;
`ifdef FPU_ALIGN_SPECIAL_EN
            s1_special_reg    <= 1'b0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_big_mant_reg   <= big_mant_next;
                s1_small_mant_reg <= small_mant_next;
                s1_shift_reg      <= shift_next;
                s1_exp_reg        <= exp_next;
                s1_sign_reg       <= sign_next;
                s1_op_reg         <= op_next;
`ifdef FPU_ALIGN_SPECIAL_EN
                s1_special_reg    <= (ua.exp == 8'hFF) || (ub.exp == 8'hFF);
`endif
            end
        end
    end

    // ---------------- stage 2: align and add/subtract ----------------
    logic [MANT_W-1:0] aligned_mant;
    logic [MANT_W:0]   sum;
    logic [MANT_W-1:0] diff;
    logic [MANT_W-1:0] mant_next;
    logic              carry_next, res_sign_next;

    align_shifter u_align_shifter (
        .mant_in  (s1_small_mant_reg),
        .shift    (s1_shift_reg),
        .mant_out (aligned_mant)
    );

    always_comb begin
        sum           = {1'b0, s1_big_mant_reg} + {1'b0, aligned_mant};
        // Ordering in stage 1 guarantees big >= aligned small, so no borrow.
        diff          = s1_big_mant_reg - aligned_mant;
        mant_next     = sum[MANT_W-1:0];
        carry_next    = sum[MANT_W];
        res_sign_next = s1_sign_reg;
        if (s1_op_reg == OP_SUB) begin
            mant_next     = diff;
            carry_next    = 1'b0;
            res_sign_next = (diff == '0) ? 1'b0 : s1_sign_reg;
        end
    end

    logic [MANT_W-1:0] result_mant_reg;
    logic              carry_out_reg, result_sign_reg, op_reg;
    logic [EXP_W-1:0]  exp_result_reg;
`ifdef FPU_ALIGN_SPECIAL_EN
    logic              special_reg;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid_reg   <= 1'b0;
            result_mant_reg <= '0;
            carry_out_reg   <= 1'b0;
            exp_result_reg  <= '0;
            result_sign_reg <= 1'b0;
            op_reg          <= OP_ADD;
`ifdef FPU_ALIGN_SPECIAL_EN
            special_reg     <= 1'b0;
`endif
        end else begin
            if (s1_advance) begin
                out_valid_reg <= s1_valid_reg;
            end
            // Only a real transfer updates the fields, so they hold during a stall.
            if (s1_valid_reg && s1_advance) begin
                result_mant_reg <= mant_next;
                carry_out_reg   <= carry_next;
                exp_result_reg  <= s1_exp_reg;
                result_sign_reg <= res_sign_next;
                op_reg          <= s1_op_reg;
`ifdef FPU_ALIGN_SPECIAL_EN
                special_reg     <= s1_special_reg;
`endif
            end
        end
    end

    assign result_mant = result_mant_reg;
    assign carry_out   = carry_out_reg;
    assign exp_result  = exp_result_reg;
    assign result_sign = result_sign_reg;
    assign op          = op_reg;
`ifdef FPU_ALIGN_SPECIAL_EN
    assign special     = special_reg;
`endif

endmodule
